// File: rtl/sha256_const_pkg.sv
// sha256_const_pkg
// Shared definitions for the SHA-256 constant streamer: the eight initial
// hash words, the sixty-four round constants, their base addresses in the
// word map, the streamer state type and a lookup helper.
// Optional feature macro used elsewhere in this slice: SHA256_CONST_WRITE_EN.
package sha256_const_pkg;

  localparam int H_BASE      = 0;
  localparam int K_BASE      = 8;
  localparam int CONST_WORDS = 72;

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROUND [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  // Word stored at a given index of the constant map; anything past the
  // last round constant reads as zero.
  function automatic logic [31:0] const_word(input logic [31:0] idx);
    if (idx < 32'(K_BASE))
      return H_INIT[3'(idx - 32'(H_BASE))];
    else if (idx < 32'(CONST_WORDS))
      return K_ROUND[6'(idx - 32'(K_BASE))];
    else
      return 32'h0;
  endfunction

endpackage

// File: rtl/sha256_const_mem.sv
// sha256_const_mem
// Word storage for the constant streamer with one synchronous read port:
// the word at rd_addr_i appears on rd_data_o after the next rising edge.
// Out-of-range addresses read as zero.
// Default build: fixed constant contents (ROM).
// With SHA256_CONST_WRITE_EN defined: RAM initialised from the package
// while rst_i is high, plus a write port; a same-edge read of the written
// address returns the old word.
// Ports:
//   clk_i      clock
//   rst_i      (write build only) reloads the constant contents
//   rd_addr_i  read word address
//   rd_data_o  registered read data
//   wr_en_i, wr_addr_i, wr_data_i  (write build only) write port
module sha256_const_mem
  import sha256_const_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 72,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
`ifdef SHA256_CONST_WRITE_EN
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
`endif
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Compared with <= so that DEPTH == 2**ADDR_W does not overflow.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] rd_data_q;

  // Package words are 32 bits; other widths zero-extend or truncate.
  function automatic logic [DATA_W-1:0] init_word(input logic [31:0] idx);
    return DATA_W'(const_word(idx));
  endfunction

`ifdef SHA256_CONST_WRITE_EN
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] ram_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= init_word(32'(i));
    end else if (wr_en_i && (wr_addr_i <= LAST_ADDR)) begin
      ram_q[IDX_W'(wr_addr_i)] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    rd_data_q <= (rd_addr_i <= LAST_ADDR) ? ram_q[IDX_W'(rd_addr_i)] : '0;
  end
`else
  always_ff @(posedge clk_i) begin
    rd_data_q <= (rd_addr_i <= LAST_ADDR) ? init_word(32'(rd_addr_i)) : '0;
  end
`endif

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sha256_const_stream.sv
// sha256_const_stream
// Streams SHA-256 initial hash words (addresses 0-7) and round constants
// (addresses 8-71) in bursts. A request (REQ_ADDR, REQ_LEN) is accepted in
// IDLE; the first word is valid two cycles after the accepting cycle and
// following words stream at one per cycle under DOUT_VALID/DOUT_READY, with
// the address wrapping from DEPTH-1 to 0. DONE pulses after the last beat
// (or for a zero-length request), ERR pulses for an out-of-range start.
// Optional macro SHA256_CONST_WRITE_EN adds a write port (WR_EN/WR_ADDR/
// WR_DATA) into a RAM-backed store.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   REQ_VALID/READY     request handshake, REQ_ADDR start word, REQ_LEN words
//   DOUT/DOUT_VALID/DOUT_READY  output word stream
//   DONE, ERR           one-cycle completion / rejection pulses
module sha256_const_stream
  import sha256_const_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 72,
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [LEN_W-1:0]  REQ_LEN,
`ifdef SHA256_CONST_WRITE_EN
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
`endif
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] dout_q, rd_data;
  logic              req_ready_q, dout_valid_q, done_q, err_q;
  logic              accept, beat, last_beat;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  sha256_const_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (CLK),
`ifdef SHA256_CONST_WRITE_EN
    .rst_i     (RST),
    .wr_en_i   (WR_EN),
    .wr_addr_i (WR_ADDR),
    .wr_data_i (WR_DATA),
`endif
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // The memory is always one word ahead of DOUT: while a word sits in the
  // output register, the read port already holds its successor, so a beat
  // can reload DOUT on the same edge.
  always_comb begin
    accept    = (state_q == IDLE) && REQ_VALID && req_ready_q;
    beat      = (state_q == STREAM) && dout_valid_q && DOUT_READY;
    last_beat = beat && (rem_q == LEN_W'(1));
    addr_d    = addr_q;
    rd_addr   = next_addr(addr_q);
    case (state_q)
      IDLE: begin
        rd_addr = REQ_ADDR;
        if (accept) addr_d = REQ_ADDR;
      end
      STREAM: begin
        if (beat && !last_beat) begin
          addr_d  = next_addr(addr_q);
          rd_addr = next_addr(addr_d);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= addr_d;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            if (REQ_ADDR > LAST_ADDR) begin
              err_q <= 1'b1;
            end else if (REQ_LEN == '0) begin
              done_q <= 1'b1;
            end else begin
              rem_q       <= REQ_LEN;
              req_ready_q <= 1'b0;
              state_q     <= LOAD;
            end
          end
        end
        LOAD: begin
          dout_q       <= rd_data;
          dout_valid_q <= 1'b1;
          state_q      <= STREAM;
        end
        STREAM: begin
          if (last_beat) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b1;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end else if (beat) begin
            dout_q <= rd_data;
            rem_q  <= rem_q - LEN_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY  = req_ready_q;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_sha256_const_stream.sv
// Testbench for sha256_const_stream: a transaction-level model (queue of
// expected words per burst) checked every cycle, plus directed literal
// checks of known SHA-256 constants, latency, backpressure and rejects.
module tb_sha256_const_stream;
  import sha256_const_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 72;
  localparam int ADDR_W = 13;
  localparam int LEN_W  = 7;

  logic              CLK, RST, REQ_VALID, REQ_READY, DOUT_VALID, DOUT_READY, DONE, ERR;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [LEN_W-1:0]  REQ_LEN;
  logic [DATA_W-1:0] DOUT;
`ifdef SHA256_CONST_WRITE_EN
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
`endif

  sha256_const_stream #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_LEN    (REQ_LEN),
`ifdef SHA256_CONST_WRITE_EN
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
`endif
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int fails     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests_run++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT, required event never seen", name);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] m_q [$];
  bit          m_ready, m_valid, m_done, m_err, m_load, started;

  function automatic logic [31:0] gold(input int i);
    if (i < 8) return H_INIT[3'(i)];
    return K_ROUND[6'(i - 8)];
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = gold(i);
  end

  always @(posedge CLK) begin
    started = 1'b1;
    if (RST) begin
      m_ready = 0; m_valid = 0; m_done = 0; m_err = 0; m_load = 0;
      m_q.delete();
`ifdef SHA256_CONST_WRITE_EN
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = gold(i);
`endif
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_load) begin
        m_load  = 0;
        m_valid = 1;
      end else if (m_valid && DOUT_READY) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_valid = 0; m_done = 1; m_ready = 1;
        end
      end else if (m_ready && REQ_VALID) begin
        if (int'(REQ_ADDR) >= DEPTH) m_err = 1;
        else if (REQ_LEN == 0) m_done = 1;
        else begin
          for (int k = 0; k < int'(REQ_LEN); k++)
            m_q.push_back(mdl_mem[(int'(REQ_ADDR) + k) % DEPTH]);
          m_load  = 1;
          m_ready = 0;
        end
      end else if (m_q.size() == 0 && !m_load) begin
        m_ready = 1;
      end
`ifdef SHA256_CONST_WRITE_EN
      if (WR_EN && int'(WR_ADDR) < DEPTH) mdl_mem[int'(WR_ADDR)] = WR_DATA;
`endif
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      check("mdl_req_ready",  {31'b0, REQ_READY},  {31'b0, m_ready});
      check("mdl_dout_valid", {31'b0, DOUT_VALID}, {31'b0, m_valid});
      check("mdl_dout",       DOUT, (m_valid && m_q.size() > 0) ? m_q[0] : 32'h0);
      check("mdl_done",       {31'b0, DONE}, {31'b0, m_done});
      check("mdl_err",        {31'b0, ERR},  {31'b0, m_err});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic request(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    bit ok;
    ok        = 0;
    REQ_ADDR  = a;
    REQ_LEN   = l;
    REQ_VALID = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      if (REQ_READY) begin ok = 1; break; end
    end
    #1 REQ_VALID = 1'b0;
    if (!ok) timeout_fail("req_handshake");
  endtask

  task automatic expect_beat(input string name, input logic [31:0] exp, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (DOUT_VALID) begin lat = c; break; end
    end
    if (lat == 0) timeout_fail(name);
    else check(name, DOUT, exp);
  endtask

  task automatic expect_done(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (DONE) begin seen = 1; break; end
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int lat;
    int beats;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_LEN = '0; DOUT_READY = 1'b1;
`ifdef SHA256_CONST_WRITE_EN
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
`endif
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_ready_low", {31'b0, REQ_READY}, 32'd0);
    check("rst_dout_zero", DOUT, 32'h0);
    check("rst_valid_low", {31'b0, DOUT_VALID}, 32'd0);
    @(negedge CLK);
    check("ready_after_rst", {31'b0, REQ_READY}, 32'd1);

    // Single-word reads
    request(13'd0, 7'd1);
    expect_beat("h0_word", 32'h6a09e667, lat);
    check("h0_latency", lat, 32'd2);
    expect_done("h0_done");
    request(13'd8, 7'd1);
    expect_beat("k0_word", 32'h428a2f98, lat);
    expect_done("k0_done");

    // Burst across the H/K boundary
    request(13'd7, 7'd3);
    expect_beat("hk_beat0", 32'h5be0cd19, lat);
    check("hk_lat0", lat, 32'd2);
    expect_beat("hk_beat1", 32'h428a2f98, lat);
    check("hk_lat1", lat, 32'd1);
    expect_beat("hk_beat2", 32'h71374491, lat);
    check("hk_lat2", lat, 32'd1);
    expect_done("hk_done");
    check("hk_ready_again", {31'b0, REQ_READY}, 32'd1);

    // Wrap with backpressure
    DOUT_READY = 1'b0;
    request(13'd71, 7'd2);
    expect_beat("wrap_first", 32'hc67178f2, lat);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("wrap_hold_data", DOUT, 32'hc67178f2);
      check("wrap_hold_valid", {31'b0, DOUT_VALID}, 32'd1);
    end
    DOUT_READY = 1'b1;
    expect_beat("wrap_second", 32'h6a09e667, lat);
    check("wrap_second_lat", lat, 32'd1);
    expect_done("wrap_done");

    // Rejects
    request(13'd100, 7'd1);
    @(negedge CLK);
    check("oob_err", {31'b0, ERR}, 32'd1);
    check("oob_no_valid", {31'b0, DOUT_VALID}, 32'd0);
    @(negedge CLK);
    check("oob_err_pulse", {31'b0, ERR}, 32'd0);
    request(13'd5, 7'd0);
    @(negedge CLK);
    check("len0_done", {31'b0, DONE}, 32'd1);
    check("len0_no_valid", {31'b0, DOUT_VALID}, 32'd0);
    check("len0_ready", {31'b0, REQ_READY}, 32'd1);

    // Reset mid-burst after 5 beats
    request(13'd8, 7'd64);
    beats = 0;
    for (int c = 0; c < 40 && beats < 5; c++) begin
      @(posedge CLK);
      if (DOUT_VALID && DOUT_READY) beats++;
    end
    if (beats < 5) timeout_fail("midrst_beats");
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("midrst_valid", {31'b0, DOUT_VALID}, 32'd0);
    check("midrst_done", {31'b0, DONE}, 32'd0);
    check("midrst_dout", DOUT, 32'h0);
    @(negedge CLK);
    check("midrst_ready", {31'b0, REQ_READY}, 32'd1);
    check("midrst_no_done", {31'b0, DONE}, 32'd0);

`ifdef SHA256_CONST_WRITE_EN
    WR_EN = 1'b1; WR_ADDR = 13'd8; WR_DATA = 32'hdeadbeef;
    @(posedge CLK);
    #1 WR_EN = 1'b0;
    @(negedge CLK);
    request(13'd8, 7'd1);
    expect_beat("wr_readback", 32'hdeadbeef, lat);
    expect_done("wr_done");
`endif

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
